// File: rtl/jtgt_encode.sv
// Jump-target encoder: turns a byte jump destination plus the jump's PC into a MIPS J/JAL word.
// Two-stage valid/ready pipeline with alignment/region checks and saturating result counters.
module jtgt_encode #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_target,
  input  logic             in_link,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [5:0]       OpJ    = 6'b000010;
  localparam logic [5:0]       OpJal  = 6'b000011;
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [25:0] s1_index_q, s1_index_d;
  logic        s1_link_q, s1_link_d;
  logic [1:0]  s1_err_q, s1_err_d;

  // Stage 2 (output) state
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic [1:0]       out_err_q, out_err_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [31:0] pc4;
  logic [1:0]  in_err;
  logic        s2_load;
  logic        in_accept;
  logic        out_xfer;

  // The J index can only reach the 256 MB region of the delay-slot address (PC + 4).
  assign pc4       = in_pc + 32'd4;
  assign in_err[0] = (in_target[1:0] != 2'b00);
  assign in_err[1] = (pc4[31:28] != in_target[31:28]);

  assign s2_load   = !out_valid_q || out_ready;
  assign in_ready  = !rst && (!s1_valid_q || !out_valid_q || out_ready);
  assign in_accept = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_index_d = s1_index_q;
    s1_link_d  = s1_link_q;
    s1_err_d   = s1_err_q;

    if (in_accept) begin
      s1_valid_d = 1'b1;
      s1_index_d = in_target[27:2];
      s1_link_d  = in_link;
      s1_err_d   = in_err;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;

    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_err_d = s1_err_q;
        if (s1_err_q == 2'b00) begin
          out_instr_d = {(s1_link_q ? OpJal : OpJ), s1_index_q};
        end else begin
          out_instr_d = 32'h0000_0000;
        end
      end
    end
  end

  always_comb begin
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;

    if (out_xfer) begin
      if (out_err_q == 2'b00) begin
        if (enc_count_q != CntMax) enc_count_d = enc_count_q + 1'b1;
      end else begin
        if (err_count_q != CntMax) err_count_d = err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      out_err_q   <= 2'b00;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  // Payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_index_q <= s1_index_d;
    s1_link_q  <= s1_link_d;
    s1_err_q   <= s1_err_d;
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_jtgt_encode.sv
// Bench for jtgt_encode: scoreboard of model-predicted results checked at each output transfer,
// plus directed checks for latency, backpressure, mid-stream reset and counter saturation.
module tb_jtgt_encode;

  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_target;
  logic             in_link;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [1:0]       out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  jtgt_encode #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_target (in_target),
    .in_link   (in_link),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  int   m_enc    = 0;
  int   m_err    = 0;
  bit   lat_req  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference encoder: {err[1:0], instr[31:0]}
  function automatic logic [33:0] model(input logic [31:0] pc, input logic [31:0] tgt,
                                        input logic link);
    logic [31:0] nxt;
    logic [1:0]  e;
    logic [31:0] w;
    nxt  = pc + 32'd4;
    e[0] = (tgt[1:0] != 2'b00);
    e[1] = (nxt[31:28] != tgt[31:28]);
    if (e != 2'b00) w = 32'h0;
    else            w = {(link ? 6'b000011 : 6'b000010), tgt[27:2]};
    return {e, w};
  endfunction

  // Monitor: inputs are driven just after posedge, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("enc_count", {30'b0, enc_count}, m_enc);
      check("err_count", {30'b0, err_count}, m_err);
      if (rst) begin
        sb.delete();
        m_enc = 0;
        m_err = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected output", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_instr", out_instr, e.instr);
            check("out_err", {30'b0, out_err}, {30'b0, e.err});
            if (e.lat) check("latency edges", cyc - e.acc + 1, 2);
            n_out++;
            if (e.err == 2'b00) begin
              if (m_enc < CNT_MAX) m_enc++;
            end else begin
              if (m_err < CNT_MAX) m_err++;
            end
          end
        end else if (out_valid && !out_ready && sb.size() > 0) begin
          check("stall out_instr", out_instr, sb[0].instr);
        end
        if (in_valid && in_ready) begin
          exp_t n;
          logic [33:0] r;
          r       = model(in_pc, in_target, in_link);
          n.instr = r[31:0];
          n.err   = r[33:32];
          n.acc   = cyc + 1;
          n.lat   = lat_req;
          sb.push_back(n);
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic link,
                      input bit lat);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_pc     = pc;
    in_target = tgt;
    in_link   = link;
    lat_req   = lat;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("send timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat_req  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] instr, input logic [1:0] err);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check({tag, " instr"}, out_instr, instr);
        check({tag, " err"}, {30'b0, out_err}, {30'b0, err});
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, " timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bp_pc [4];
  logic [31:0] bp_tgt[4];
  int          idx;
  int          out_base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_target = '0;
    in_link   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Basic J, JAL and region-wrap cases
    send(32'h0040_0000, 32'h0040_0020, 1'b0, 1'b1);
    expect_out("basic J", 32'h0810_0008, 2'b00);
    drain();
    check("basic enc_count", {30'b0, enc_count}, 32'd1);
    send(32'h0040_0000, 32'h0040_0020, 1'b1, 1'b1);
    expect_out("JAL", 32'h0C10_0008, 2'b00);
    send(32'h0FFF_FFFC, 32'h1000_0000, 1'b0, 1'b1);
    expect_out("region edge", 32'h0800_0000, 2'b00);
    send(32'hFFFF_FFFC, 32'h0000_0040, 1'b0, 1'b1);
    expect_out("pc4 wrap", 32'h0800_0010, 2'b00);
    drain();

    // Error cases
    send(32'h0040_0000, 32'h0040_0022, 1'b0, 1'b1);
    expect_out("misaligned", 32'h0, 2'b01);
    send(32'h0FFF_FFF8, 32'h1000_0000, 1'b0, 1'b1);
    expect_out("region", 32'h0, 2'b10);
    send(32'h0FFF_FFF8, 32'h1000_0002, 1'b0, 1'b1);
    expect_out("both errs", 32'h0, 2'b11);
    drain();
    check("err err_count", {30'b0, err_count}, 32'd3);
    check("err enc_count", {30'b0, enc_count}, 32'd3);

    // Backpressure: four offers against a stalled output
    for (int i = 0; i < 4; i++) begin
      bp_pc[i]  = 32'h0040_0000;
      bp_tgt[i] = 32'h0040_0100 + 32'(i * 4);
    end
    bp_tgt[2] = 32'h0040_0101;
    out_ready = 1'b0;
    idx       = 0;
    out_base  = n_out;
    for (int c = 0; c < 4; c++) begin
      in_valid  = 1'b1;
      in_pc     = bp_pc[idx];
      in_target = bp_tgt[idx];
      in_link   = idx[0];
      @(negedge clk);
      if (c >= 2) check("bp in_ready low", {31'b0, in_ready}, 32'd0);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("bp accepted", idx, 2);
    out_ready = 1'b1;
    in_pc     = bp_pc[idx];
    in_target = bp_tgt[idx];
    in_link   = idx[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp no gap", {31'b0, out_valid}, 32'd1);
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
      if (idx >= 4) begin
        in_valid = 1'b0;
      end else begin
        in_pc     = bp_pc[idx];
        in_target = bp_tgt[idx];
        in_link   = idx[0];
      end
    end
    in_valid = 1'b0;
    drain();
    check("bp delivered", n_out - out_base, 4);

    // Reset with both stages full
    out_ready = 1'b0;
    send(32'h0040_0000, 32'h0040_0200, 1'b0, 1'b0);
    send(32'h0040_0000, 32'h0040_0204, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-rst out_valid", {31'b0, out_valid}, 32'd0);
    check("post-rst enc_count", {30'b0, enc_count}, 32'd0);
    check("post-rst err_count", {30'b0, err_count}, 32'd0);
    check("post-rst in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'h0040_0000, 32'h0040_0020, 1'b1, 1'b1);
    expect_out("post-rst JAL", 32'h0C10_0008, 2'b00);
    drain();

    // Saturation: counters are 2 bits wide here
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h0040_0000, 32'h0040_0000 + 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(32'h0040_0000, 32'h0040_0001 + 32'(i * 4), 1'b0, 1'b0);
    drain();
    check("sat enc_count", {30'b0, enc_count}, 32'd3);
    check("sat err_count", {30'b0, err_count}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
